// File: rtl/reg_file_pkg.sv
// Shared register-file constants for the RV32I core and the register file.
package reg_file_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]       reg_word_t;

endpackage

// File: rtl/reg_file_checker.sv
// Property checks on the register-file decoder and read ports.
module reg_file_checker #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input logic                 clk,
  input logic                 rst,
  input logic [2**ADDR_W-1:0] wen,
  input logic [ADDR_W-1:0]    rs1_addr,
  input logic [ADDR_W-1:0]    rs2_addr,
  input logic [XLEN-1:0]      rs1_data,
  input logic [XLEN-1:0]      rs2_data
);

  a_wen_onehot0: assert property (@(posedge clk) $onehot0(wen));
  a_wen_x0:      assert property (@(posedge clk) wen[0] == 1'b0);
  a_rs1_x0:      assert property (@(posedge clk) disable iff (rst)
                                  (rs1_addr == '0) |-> (rs1_data == '0));
  a_rs2_x0:      assert property (@(posedge clk) disable iff (rst)
                                  (rs2_addr == '0) |-> (rs2_data == '0));

endmodule

// File: rtl/reg_file_write_decoder.sv
// One-hot write-enable decoder for the register file; x0 never receives an enable.
module write_decoder #(
  parameter int ADDR_W = 5
) (
  input  logic                 we,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [2**ADDR_W-1:0] wen
);

  localparam int NREGS = 2**ADDR_W;

  // decode rd_addr into a single enable bit, leaving bit 0 permanently low
  always_comb begin
    wen = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (we && (rd_addr == ADDR_W'(i))) begin
        wen[i] = 1'b1;
      end else begin
        wen[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32 x XLEN integer register file: one clocked write port, two combinational
// read ports, x0 hardwired to zero, optional write-to-read bypass.
import reg_file_pkg::*;

module reg_file #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]   rd_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data
);

  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0] wen_s;
  logic [XLEN-1:0]  regs_r [NREGS];

  write_decoder #(
    .ADDR_W (ADDR_W)
  ) u_write_decoder (
    .we      (we),
    .rd_addr (rd_addr),
    .wen     (wen_s)
  );

  // storage array: reset clears every entry and takes priority over writes
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (rst) begin
        regs_r[i] <= '0;
      end else if (wen_s[i]) begin
        regs_r[i] <= rd_data;
      end else begin
        regs_r[i] <= regs_r[i];
      end
    end
  end

  // read port 1; forwarding is suppressed while reset discards the write
  always_comb begin
    rs1_data = '0;
    if (rs1_addr == ADDR_W'(ZERO_REG)) begin
      rs1_data = '0;
    end else if ((BYPASS != 0) && !rst && wen_s[rs1_addr]) begin
      rs1_data = rd_data;
    end else begin
      rs1_data = regs_r[rs1_addr];
    end
  end

  // read port 2
  always_comb begin
    rs2_data = '0;
    if (rs2_addr == ADDR_W'(ZERO_REG)) begin
      rs2_data = '0;
    end else if ((BYPASS != 0) && !rst && wen_s[rs2_addr]) begin
      rs2_data = rd_data;
    end else begin
      rs2_data = regs_r[rs2_addr];
    end
  end

  reg_file_checker #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) u_checker (
    .clk      (clk),
    .rst      (rst),
    .wen      (wen_s),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed, table-driven bench for reg_file; one instance without and one with bypass.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_nb;
  logic [31:0] rs2_nb;
  logic [31:0] rs1_by;
  logic [31:0] rs2_by;

  int nvec;
  int nerr;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] b1;
    logic [31:0] b2;
  } vec_t;

  vec_t tbl [13];

  reg_file #(.XLEN(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_nb),
    .rs2_data (rs2_nb)
  );

  reg_file #(.XLEN(32), .ADDR_W(5), .BYPASS(1)) dut_by (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_by),
    .rs2_data (rs2_by)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] b1, input logic [31:0] b2);
    check({name, " nb.rs1"}, rs1_nb, e1);
    check({name, " nb.rs2"}, rs2_nb, e2);
    check({name, " by.rs1"}, rs1_by, b1);
    check({name, " by.rs2"}, rs2_by, b2);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;

    // Reads observed just before the edge on which the row's write is taken.
    //          rst   we    rd     wd            a1     a2     e1            e2            b1            b2
    tbl[0]  = '{1'b0, 1'b1, 5'd10, 32'h00000015, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    tbl[1]  = '{1'b0, 1'b1, 5'd11, 32'h0000000A, 5'd10, 5'd10, 32'h15,       32'h15,       32'h15,       32'h15};
    tbl[2]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd11, 5'd10, 32'h0A,       32'h15,       32'h0A,       32'h15};
    tbl[3]  = '{1'b0, 1'b0, 5'd3,  32'h00001234, 5'd0,  5'd3,  32'h0,        32'h0,        32'h0,        32'h0};
    tbl[4]  = '{1'b0, 1'b0, 5'd3,  32'h00001234, 5'd3,  5'd11, 32'h0,        32'h0A,       32'h0,        32'h0A};
    tbl[5]  = '{1'b0, 1'b1, 5'd7,  32'h00000001, 5'd10, 5'd0,  32'h15,       32'h0,        32'h15,       32'h0};
    tbl[6]  = '{1'b0, 1'b1, 5'd7,  32'h00000002, 5'd7,  5'd7,  32'h1,        32'h1,        32'h2,        32'h2};
    tbl[7]  = '{1'b0, 1'b1, 5'd7,  32'h00000003, 5'd7,  5'd10, 32'h2,        32'h15,       32'h3,        32'h15};
    tbl[8]  = '{1'b0, 1'b0, 5'd7,  32'h00000000, 5'd7,  5'd0,  32'h3,        32'h0,        32'h3,        32'h0};
    tbl[9]  = '{1'b1, 1'b1, 5'd4,  32'h000000AA, 5'd10, 5'd7,  32'h15,       32'h3,        32'h15,       32'h3};
    tbl[10] = '{1'b0, 1'b0, 5'd4,  32'h00000000, 5'd4,  5'd10, 32'h0,        32'h0,        32'h0,        32'h0};
    tbl[11] = '{1'b0, 1'b1, 5'd31, 32'h80000001, 5'd31, 5'd30, 32'h0,        32'h0,        32'h80000001, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 5'd31, 32'h00000000, 5'd31, 5'd31, 32'h80000001, 32'h80000001, 32'h80000001, 32'h80000001};

    rst = 1'b1; we = 1'b0; rd_addr = 5'd0; rd_data = 32'h0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    @(negedge clk);
    @(negedge clk);

    // preload x5, then reset must wipe it and every other entry
    rst = 1'b0; we = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
    @(negedge clk);
    we = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd5;
    #1;
    check_all("preload x5", 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("reset x5", 32'h0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      check($sformatf("reset clear nb.rs1 x%0d", i), rs1_nb, 32'h0);
      check($sformatf("reset clear by.rs2 x%0d", 31 - i), rs2_by, 32'h0);
    end

    // table: rows start with a fresh register file after this reset
    rst = 1'b1;
    @(negedge clk);
    for (int v = 0; v < 13; v++) begin
      rst = tbl[v].rst; we = tbl[v].we; rd_addr = tbl[v].rd; rd_data = tbl[v].wd;
      rs1_addr = tbl[v].a1; rs2_addr = tbl[v].a2;
      #1;
      check_all($sformatf("vec%0d", v), tbl[v].e1, tbl[v].e2, tbl[v].b1, tbl[v].b2);
      @(negedge clk);
    end

    // walking write of each index into itself, then read back on both ports
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; rd_addr = 5'(i); rd_data = 32'(i);
      @(negedge clk);
    end
    we = 1'b0; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(i);
      #1;
      check_all($sformatf("walk x%0d", i), 32'(i), 32'(i), 32'(i), 32'(i));
    end

    // x0 write with bypass instance still reads zero in the same cycle
    @(negedge clk);
    we = 1'b1; rd_addr = 5'd0; rd_data = 32'h5A5A5A5A; rs1_addr = 5'd0; rs2_addr = 5'd9;
    #1;
    check_all("x0 write same cycle", 32'h0, 32'h9, 32'h0, 32'h9);
    @(negedge clk);
    we = 1'b0;
    #1;
    check_all("x0 write after edge", 32'h0, 32'h9, 32'h0, 32'h9);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
